// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: state encoding, strobe bundle and sizing helpers for the shift-add multiplier controller.
package shift_add_mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_e;
  typedef struct packed {
    logic load_ab;
    logic clear_acc;
    logic shift;
    logic busy;
    logic done;
  } ctrl_out_t;
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction
  function automatic ctrl_out_t decode(input state_e s);
    return '{load_ab: s == LOAD, clear_acc: s == LOAD, shift: s == SHIFT, busy: s != IDLE, done: s == DONE};
  endfunction
endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: start/done handshake plus datapath status and strobes between parent and controller.
interface shift_add_mult_ctrl_if;
  logic start;
  logic b_lsb;
  logic b_zero;
  logic load_ab;
  logic clear_acc;
  logic load_acc;
  logic shift;
  logic busy;
  logic done;
  modport master (output start, b_lsb, b_zero, input load_ab, clear_acc, load_acc, shift, busy, done);
  modport slave (input start, b_lsb, b_zero, output load_ab, clear_acc, load_acc, shift, busy, done);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: Moore FSM sequencing a WIDTH-iteration shift-add multiply.
// SHIFT_ADD_MULT_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic clear_n,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_out_t out_q;
  logic last;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = IDLE;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = bus.start ? LOAD : IDLE;
      LOAD: begin
        state_d = EVAL;
        cnt_d = '0;
      end
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
      EVAL: state_d = bus.b_zero ? DONE : SHIFT;
`else
      EVAL: state_d = SHIFT;
`endif
      SHIFT: begin
        state_d = last ? DONE : EVAL;
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // strobes are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= decode(state_d);
    end
  end
  assign bus.load_ab = out_q.load_ab;
  assign bus.clear_acc = out_q.clear_acc;
  assign bus.shift = out_q.shift;
  assign bus.busy = out_q.busy;
  assign bus.done = out_q.done;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  assign bus.load_acc = (state_q == EVAL) && bus.b_lsb && !bus.b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = bus.b_zero;
  assign bus.load_acc = (state_q == EVAL) && bus.b_lsb;
`endif
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: drives the controller against a behavioural datapath and multiply/latency reference.
module tb_shift_add_mult_ctrl;
  localparam int W = 8;
  logic clk = 0;
  logic clear_n;
  int checks = 0;
  int failures = 0;
  logic [7:0] op_a, op_b, b_r;
  logic [15:0] a_r, acc;
  shift_add_mult_ctrl_if bus();
  shift_add_mult_ctrl #(.WIDTH(W)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.load_ab) begin
      a_r <= {8'h00, op_a};
      b_r <= op_b;
    end
    if (bus.clear_acc) acc <= '0;
    if (bus.load_acc) acc <= acc + a_r;
    if (bus.shift) begin
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
    end
  end
  assign bus.b_lsb = b_r[0];
  assign bus.b_zero = (b_r == 8'h00);
  function automatic int top_k(input logic [7:0] b);
    int k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
  endfunction
  function automatic int exp_lat(input logic [7:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    return top_k(b) < W ? 2 * top_k(b) + 2 : 2 * W + 1;
`else
    return 2 * W + 1;
`endif
  endfunction
  function automatic int exp_shifts(input logic [7:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    return top_k(b) < W ? top_k(b) : W;
`else
    return W;
`endif
  endfunction
  function automatic logic [5:0] outs();
    return {bus.load_ab, bus.clear_acc, bus.load_acc, bus.shift, bus.busy, bus.done};
  endfunction
  // Called at a negedge; j counts negedges after the edge that samples start.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int p1, input int p2,
                        output int done_j, output int n_done, output int n_shift, output int n_la,
                        output logic [7:0] la_pat, output logic first_ok, output logic busy_after,
                        output int excl_bad);
    op_a = a;
    op_b = b;
    bus.start = 1;
    done_j = -1; n_done = 0; n_shift = 0; n_la = 0; la_pat = '0; first_ok = 0; busy_after = 1; excl_bad = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      bus.start = (j == p1 || j == p2);
      if (j == 0) first_ok = bus.load_ab && bus.clear_acc && bus.busy;
      if (bus.done) begin
        n_done++;
        if (done_j < 0) done_j = j;
      end
      if (bus.shift) n_shift++;
      if (bus.load_acc) begin
        n_la++;
        if (j % 2 == 1 && j < 2 * W) la_pat[j / 2] = 1'b1;
      end
      if (int'(bus.load_ab | bus.clear_acc) + int'(bus.load_acc) + int'(bus.shift) > 1) excl_bad++;
      if (done_j >= 0 && j == done_j + 1) busy_after = bus.busy;
      if (done_j >= 0 && j == done_j + 4) break;
    end
    bus.start = 0;
  endtask
  task automatic test_reset();
    int dj, nd, ns, nl, ex;
    logic [7:0] lp;
    logic fo, ba;
    clear_n = 1;
    bus.start = 0;
    #2 clear_n = 0;
    #1;
    checks++;
    if (outs() !== 6'b0) begin failures++; $display("FAIL reset_async outs=%b exp=000000", outs()); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (outs() !== 6'b0) begin failures++; $display("FAIL reset_hold outs=%b exp=000000", outs()); end
    end
    clear_n = 1;
    @(negedge clk);
    run_op(8'h0B, 8'hA5, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
    checks++;
    if (fo !== 1'b1) begin failures++; $display("FAIL first_load got=%b exp=1", fo); end
  endtask
  task automatic test_a5();
    int dj, nd, ns, nl, ex;
    logic [7:0] lp;
    logic fo, ba;
    run_op(8'h0B, 8'hA5, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
    checks += 6;
    if (dj != 2 * W + 1) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", dj, 2 * W + 1); end
    if (nd != 1) begin failures++; $display("FAIL a5_done_count got=%0d exp=1", nd); end
    if (ns != W) begin failures++; $display("FAIL a5_shifts got=%0d exp=%0d", ns, W); end
    if (lp !== 8'hA5) begin failures++; $display("FAIL a5_load_acc_visits got=%h exp=a5", lp); end
    if (acc !== 16'h0717) begin failures++; $display("FAIL a5_acc got=%h exp=0717", acc); end
    if (ex != 0 || ba !== 1'b0) begin failures++; $display("FAIL a5_excl_busy excl=%0d busy_after=%b exp=0,0", ex, ba); end
  endtask
  task automatic test_random();
    int dj, nd, ns, nl, ex;
    logic [7:0] lp, a, b;
    logic fo, ba;
    for (int n = 0; n < 8; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (n == 1) b = 8'h01;
      if (n == 2) b = 8'h40;
      run_op(a, b, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
      checks += 5;
      if (acc !== 16'(a) * 16'(b)) begin failures++; $display("FAIL rand_product a=%h b=%h got=%h exp=%h", a, b, acc, 16'(a) * 16'(b)); end
      if (dj != exp_lat(b)) begin failures++; $display("FAIL rand_latency b=%h got=%0d exp=%0d", b, dj, exp_lat(b)); end
      if (ns != exp_shifts(b)) begin failures++; $display("FAIL rand_shifts b=%h got=%0d exp=%0d", b, ns, exp_shifts(b)); end
      if (nl != $countones(b) || lp !== b) begin failures++; $display("FAIL rand_load_acc b=%h got=%h/%0d", b, lp, nl); end
      if (nd != 1 || ex != 0 || fo !== 1'b1) begin failures++; $display("FAIL rand_handshake b=%h done=%0d excl=%0d first=%b", b, nd, ex, fo); end
    end
  endtask
  task automatic test_ignore();
    int dj, nd, ns, nl, ex;
    logic [7:0] lp;
    logic fo, ba;
    run_op(8'h37, 8'h81, 1, exp_lat(8'h81), dj, nd, ns, nl, lp, fo, ba, ex);
    checks += 4;
    if (nd != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
    if (dj != exp_lat(8'h81)) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", dj, exp_lat(8'h81)); end
    if (ba !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b exp=0", ba); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_requeue busy=%b exp=0", bus.busy); end
  endtask
  task automatic test_back_to_back();
    int d[$];
    int idle = 0;
    int seen = 0;
    op_a = 8'h5C;
    op_b = 8'hA5;
    bus.start = 1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done) d.push_back(j);
      if (!bus.busy) idle++;
    end
    bus.start = 0;
    for (int j = 0; j < 40 && seen == 0; j++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    @(negedge clk);
    checks += 4;
    if (d.size() != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", d.size()); end
    else if (d[0] != 2 * W + 1 || d[1] != 4 * W + 4) begin failures++; $display("FAIL b2b_done_edges got=%0d,%0d exp=%0d,%0d", d[0], d[1], 2 * W + 1, 4 * W + 4); end
    if (idle != 2) begin failures++; $display("FAIL b2b_idle_cycles got=%0d exp=2", idle); end
    if (seen != 1) begin failures++; $display("FAIL b2b_third_done got=%0d exp=1", seen); end
    if (acc !== 16'h5C * 16'hA5) begin failures++; $display("FAIL b2b_acc got=%h exp=%h", acc, 16'h5C * 16'hA5); end
  endtask
  task automatic test_abort();
    int dj, nd, ns, nl, ex;
    int bad = 0;
    logic [7:0] lp;
    logic fo, ba;
    op_a = 8'h21;
    op_b = 8'hFF;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.shift !== 1'b1) begin failures++; $display("FAIL abort_in_shift got=%b exp=1", bus.shift); end
    #2 clear_n = 0;
    #1;
    checks++;
    if (outs() !== 6'b0) begin failures++; $display("FAIL abort_async outs=%b exp=000000", outs()); end
    repeat (3) begin
      @(negedge clk);
      if (outs() !== 6'b0) bad++;
    end
    clear_n = 1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
    run_op(8'h21, 8'hFF, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
    checks += 2;
    if (dj != 2 * W + 1) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=%0d", dj, 2 * W + 1); end
    if (acc !== 16'h21 * 16'hFF) begin failures++; $display("FAIL abort_restart_acc got=%h exp=%h", acc, 16'h21 * 16'hFF); end
  endtask
  task automatic test_early();
    int dj, nd, ns, nl, ex;
    logic [7:0] lp;
    logic fo, ba;
    run_op(8'h0B, 8'h03, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
    checks += 3;
    if (dj != exp_lat(8'h03)) begin failures++; $display("FAIL early03_latency got=%0d exp=%0d", dj, exp_lat(8'h03)); end
    if (ns != exp_shifts(8'h03)) begin failures++; $display("FAIL early03_shifts got=%0d exp=%0d", ns, exp_shifts(8'h03)); end
    if (acc !== 16'h0021) begin failures++; $display("FAIL early03_acc got=%h exp=0021", acc); end
    run_op(8'h0B, 8'h00, -1, -1, dj, nd, ns, nl, lp, fo, ba, ex);
    checks += 3;
    if (dj != exp_lat(8'h00)) begin failures++; $display("FAIL early00_latency got=%0d exp=%0d", dj, exp_lat(8'h00)); end
    if (nl != 0) begin failures++; $display("FAIL early00_load_acc got=%0d exp=0", nl); end
    if (acc !== 16'h0000 || nd != 1) begin failures++; $display("FAIL early00_acc_done acc=%h done=%0d exp=0000,1", acc, nd); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_a5();
    test_random();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_early();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
